// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Two-entry elastic (skid) pipeline stage with hazard freeze,
//             branch flush and saturating stall/flush statistics counters.
//  Ports    : clk, rst            - clock, async active-high reset
//             freeze, flush       - hold all state / discard all entries
//             in_valid/in_ready/in_data    - upstream handshake + payload
//             out_valid/out_ready/out_data - downstream handshake + payload
//             stall_cnt, flush_cnt         - saturating statistics counters
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_push;
    logic w_pop;
    logic w_main_ld_in;
    logic w_main_ld_skid;
    logic w_skid_ld_in;
    logic w_stall;

    // Freeze and flush both close the handshakes, so no push/pop can happen
    // while either is asserted; holding state under freeze falls out of that.
    assign in_ready  = (r_state != S_FULL)  && !freeze && !flush;
    assign out_valid = (r_state != S_EMPTY) && !freeze && !flush;
    assign w_push    = in_valid  && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_stall   = (freeze && !flush) || (out_valid && !out_ready);

    // Occupancy next-state and data-path load enables
    always_comb begin
        w_state_nxt    = r_state;
        w_main_ld_in   = 1'b0;
        w_main_ld_skid = 1'b0;
        w_skid_ld_in   = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_main_ld_in = 1'b1;
                        w_state_nxt  = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        w_main_ld_in = 1'b1;
                    end else if (w_push) begin
                        w_skid_ld_in = 1'b1;
                        w_state_nxt  = S_FULL;
                    end else if (w_pop) begin
                        w_state_nxt  = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_main_ld_skid = 1'b1;
                        w_state_nxt    = S_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main/skid registers; main keeps its last value when the stage drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= FLUSH_VAL;
            r_skid <= FLUSH_VAL;
        end else if (flush) begin
            r_main <= FLUSH_VAL;
            r_skid <= FLUSH_VAL;
        end else begin
            if (w_main_ld_in) begin
                r_main <= in_data;
            end else if (w_main_ld_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_ld_in) begin
                r_skid <= in_data;
            end
        end
    end

    // Saturating statistics; a flush of an already empty stage is not counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush && (r_state != S_EMPTY) && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign out_data  = r_main;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Directed self-checking bench for pipe_stage_reg (reset,
//             streaming, skid, freeze, flush, mid-transfer reset, saturation).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          freeze = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cnt;
    logic [15:0]   flush_cnt;

    // Second instance dedicated to counter saturation (CNT_W = 2)
    logic          s_freeze = 1'b0;
    logic          s_in_ready;
    logic          s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_stall_cnt;
    logic [1:0]    s_flush_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [DW-1:0] c_a = 64'h0F0F0F0F_33333333;
    localparam logic [DW-1:0] c_b = 64'h11111111_22222222;
    localparam logic [DW-1:0] c_c = 64'hCCCC0000_0000CCCC;
    localparam logic [DW-1:0] c_d = 64'hDDDD1111_2222DDDD;
    localparam logic [DW-1:0] c_e = 64'h55AA0000_12345678;
    localparam logic [DW-1:0] c_f = 64'hFFFF0000_0000FFFF;
    localparam logic [DW-1:0] c_g = 64'h9999AAAA_BBBBCCCC;
    localparam logic [DW-1:0] c_h = 64'h12345678_9ABCDEF0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .freeze   (freeze),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(2)) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .freeze   (s_freeze),
        .flush    (1'b0),
        .in_valid (1'b0),
        .in_ready (s_in_ready),
        .in_data  ({DW{1'b0}}),
        .out_valid(s_out_valid),
        .out_ready(1'b0),
        .out_data (s_out_data),
        .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data got %h exp %h", out_data, 64'd0); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
        checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_flush_cnt got %0d exp 0", flush_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        in_valid = 1'b1; in_data = c_a; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== c_a) begin errors++; $display("FAIL stream_first got v=%b %h exp v=1 %h", out_valid, out_data, c_a); end
        in_data = c_b;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== c_b) begin errors++; $display("FAIL stream_second got v=%b %h exp v=1 %h", out_valid, out_data, c_b); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== c_b) begin errors++; $display("FAIL stream_drain got v=%b %h exp v=0 %h", out_valid, out_data, c_b); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall_cnt got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0; in_valid = 1'b1; in_data = c_c;
        tick();
        in_data = c_d;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_one_in_ready got %b exp 1", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== c_c) begin errors++; $display("FAIL skid_full got rdy=%b v=%b %h exp rdy=0 v=1 %h", in_ready, out_valid, out_data, c_c); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL skid_stall1 got %0d exp 1", stall_cnt); end
        in_valid = 1'b0;
        tick();
        checks++; if (stall_cnt !== 16'd2 || out_data !== c_c) begin errors++; $display("FAIL skid_stall2 got %0d %h exp 2 %h", stall_cnt, out_data, c_c); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== c_d || in_ready !== 1'b1) begin errors++; $display("FAIL skid_pop_a got v=%b %h rdy=%b exp v=1 %h rdy=1", out_valid, out_data, in_ready, c_d); end
        tick();
        checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd2) begin errors++; $display("FAIL skid_pop_b got v=%b stall=%0d exp v=0 stall=2", out_valid, stall_cnt); end
    endtask

    task automatic test_freeze();
        out_ready = 1'b0; in_valid = 1'b1; in_data = c_e;
        tick();
        freeze = 1'b1; in_data = c_f;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== c_e) begin errors++; $display("FAIL freeze_outputs got rdy=%b v=%b %h exp rdy=0 v=0 %h", in_ready, out_valid, out_data, c_e); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (stall_cnt !== 16'd5 || out_data !== c_e) begin errors++; $display("FAIL freeze_hold got stall=%0d %h exp stall=5 %h", stall_cnt, out_data, c_e); end
        freeze = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== c_e || stall_cnt !== 16'd6) begin errors++; $display("FAIL freeze_resume got rdy=%b v=%b %h stall=%0d exp rdy=0 v=1 %h stall=6", in_ready, out_valid, out_data, stall_cnt, c_e); end
    endtask

    task automatic test_flush();
        freeze = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = c_g;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 64'd0 || flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_full got v=%b %h fcnt=%0d exp v=0 0 fcnt=1", out_valid, out_data, flush_cnt); end
        checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL flush_stall got %0d exp 6", stall_cnt); end
        freeze = 1'b0;
        tick();
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_empty_cnt got %0d exp 1", flush_cnt); end
        flush = 1'b0; in_valid = 1'b1; in_data = c_h; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== c_h) begin errors++; $display("FAIL flush_repush got v=%b %h exp v=1 %h", out_valid, out_data, c_h); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== c_h) begin errors++; $display("FAIL flush_no_stale got v=%b %h exp v=0 %h", out_valid, out_data, c_h); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_data = c_a;
        tick();
        in_data = c_b;
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'd0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_mid got v=%b rdy=%b %h stall=%0d exp v=0 rdy=1 0 stall=0", out_valid, in_ready, out_data, stall_cnt); end
        rst = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_discard got v=%b exp 0", out_valid); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        s_freeze = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            if (n == 6) s_freeze = 1'b0;
            tick();
            exp_cnt = (n >= 3) ? 2'd3 : n[1:0];
            checks++; if (s_stall_cnt !== exp_cnt) begin errors++; $display("FAIL sat_cycle%0d got %0d exp %0d", n, s_stall_cnt, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_freeze();
        test_flush();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the stage payload width (for example PC and instruction concatenated).
REQ-002 The block SHALL have parameter FLUSH_VAL, default all-zero DATA_W, giving the bubble value loaded into the data registers on reset and flush.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of each statistics counter.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset; reset is asynchronous and active-high.
REQ-006 The block SHALL have port freeze, input, 1 bit, a hazard stall that holds all stage state.
REQ-007 The block SHALL have port flush, input, 1 bit, a branch flush that discards all buffered entries.
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning the upstream offers in_data.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the stage can accept an entry.
REQ-010 The block SHALL have port in_data, input, DATA_W bits, the upstream payload.
REQ-011 The block SHALL have port out_valid, output, 1 bit, meaning out_data holds a live entry.
REQ-012 The block SHALL have port out_ready, input, 1 bit, meaning downstream consumes the entry.
REQ-013 The block SHALL have port out_data, output, DATA_W bits, the head entry payload.
REQ-014 The block SHALL have port stall_cnt, output, CNT_W bits, counting stall cycles.
REQ-015 The block SHALL have port flush_cnt, output, CNT_W bits, counting effective flushes.

Function
REQ-016 The block SHALL be a 2-entry elastic (skid) stage made of a main register, which drives out_data, and a skid register.
REQ-017 The occupancy state machine SHALL have the states EMPTY, ONE and FULL.
REQ-018 The handshake SHALL define push = in_valid and in_ready, and pop = out_valid and out_ready.
REQ-019 in_ready SHALL equal (state is not FULL) and not freeze and not flush.
REQ-020 out_valid SHALL equal (state is not EMPTY) and not freeze and not flush.
REQ-021 From EMPTY, a push SHALL load main with in_data and move to ONE; with no push the state SHALL stay EMPTY.
REQ-022 From ONE, push and pop together SHALL load main with in_data and stay in ONE.
REQ-023 From ONE, push only SHALL load skid with in_data and move to FULL.
REQ-024 From ONE, pop only SHALL move to EMPTY and leave main unchanged.
REQ-025 From FULL, pop SHALL copy skid to main and move to ONE; without pop the state SHALL stay FULL (push is impossible because in_ready is 0).
REQ-026 Latency SHALL be 1 cycle from the push edge to out_valid=1 with the pushed data on out_data.
REQ-027 Sustained throughput SHALL be 1 entry per cycle while out_ready=1.
REQ-028 Ordering SHALL be FIFO, with no loss or duplication.
REQ-029 While freeze=1 and flush=0, state, main, skid and flush_cnt SHALL hold their values.
REQ-030 flush=1 SHALL take priority over freeze, push and pop.
REQ-031 On a flush edge the state SHALL become EMPTY and main and skid SHALL load FLUSH_VAL; in_data offered in that cycle SHALL be dropped.
REQ-032 In EMPTY, out_data SHALL keep the last main value; only reset or flush force FLUSH_VAL.
REQ-033 stall_cnt SHALL increment each cycle in which (freeze=1 and flush=0), or (out_valid=1 and out_ready=0).
REQ-034 flush_cnt SHALL increment on each flush cycle in which the state is not EMPTY.
REQ-035 Both counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.

Reset
REQ-036 When rst=1, the state SHALL become EMPTY immediately (asynchronously), independent of clk.
REQ-037 When rst=1, main and skid SHALL become FLUSH_VAL and both counters SHALL become 0.
REQ-038 Reset asserted mid-transfer SHALL discard all entries; outputs SHALL be in_ready=1 (if freeze=0 and flush=0), out_valid=0 and out_data=FLUSH_VAL.
REQ-039 After rst deasserts, the first push SHALL be accepted on the next rising edge.

Verification
REQ-040 Reset scenario: rst pulsed at 3 ns, between clock edges -> out_data=0, out_valid=0, in_ready=1, stall_cnt=0 and flush_cnt=0 before the next edge.
REQ-041 Streaming scenario: push 0x0F0F0F0F_33333333, then 0x11111111_22222222 back-to-back with out_ready=1 -> each appears on out_data 1 cycle after its push, with no gaps.
REQ-042 Skid scenario: out_ready=0, push A then B -> state FULL, in_ready=0, out_data=A, stall_cnt increments each cycle; then out_ready=1 -> A, then B, each popped on consecutive cycles.
REQ-043 Freeze scenario: state ONE holding 0x55AA_xxxx, freeze=1 for 3 cycles while in_valid=1 -> out_data unchanged, in_ready=0, out_valid=0, stall_cnt increases by 3.
REQ-044 Flush scenario: FULL with freeze=1 and flush=1 together -> next edge gives EMPTY, out_data=0 and flush_cnt=1; a second flush while EMPTY leaves flush_cnt=1.
REQ-045 Saturation scenario: CNT_W=2 with 5 stall cycles -> stall_cnt=3 and stays at 3.
